// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2,
    S_ERROR
  } state_e;

  // How the ALU decoder should pick an operation in the current state.
  typedef enum logic [1:0] {
    ALU_MODE_ADD,
    ALU_MODE_SUB,
    ALU_MODE_FUNCT
  } alu_mode_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_F3_BEQ = 3'b000;
  localparam logic [2:0] BR_F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder_ext.sv
// Combinational ALU operation decoder; the extended operations exist only
// when the ALU control word is at least four bits wide.
module alu_decoder_ext
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_W = 3
) (
  input  alu_mode_e        alu_mode_i,
  input  logic [2:0]       f3_i,
  input  logic             f7_i,
  input  logic             op5_i,
  output logic [ALU_W-1:0] alu_control_o
);

  logic [2:0] base_code;

  always_comb begin
    base_code = ALU_ADD;
    case (alu_mode_i)
      ALU_MODE_SUB: base_code = ALU_SUB;
      ALU_MODE_FUNCT: begin
        case (f3_i)
          // Immediate forms (op[5]=0) never subtract, whatever bit 30 holds.
          F3_ADD:  base_code = (f7_i && op5_i) ? ALU_SUB : ALU_ADD;
          F3_SLT:  base_code = ALU_SLT;
          F3_OR:   base_code = ALU_OR;
          F3_AND:  base_code = ALU_AND;
          default: base_code = ALU_ADD;
        endcase
      end
      default: base_code = ALU_ADD;
    endcase
  end

  generate
    if (ALU_W >= 4) begin : g_ext
      logic [3:0] ext_code;
      logic       ext_hit;

      always_comb begin
        ext_hit  = (alu_mode_i == ALU_MODE_FUNCT);
        ext_code = ALU_XOR;
        case (f3_i)
          F3_XOR:  ext_code = ALU_XOR;
          F3_SLL:  ext_code = ALU_SLL;
          F3_SR:   ext_code = f7_i ? ALU_SRA : ALU_SRL;
          F3_SLTU: ext_code = ALU_SLTU;
          default: ext_hit  = 1'b0;
        endcase
      end

      assign alu_control_o = ext_hit ? ALU_W'(ext_code) : ALU_W'(base_code);
    end else begin : g_base
      assign alu_control_o = ALU_W'(base_code);
    end
  endgenerate

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V style control FSM: one state register, combinational
// next-state and output decode, with write strobes gated off during reset.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_W  = 3,
  parameter int BR_EXT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       f3,
  input  logic             f7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             regWrite,
  output logic             memWrite,
  output logic             adrSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       resultSrc,
  output logic [1:0]       immSrc,
  output logic [ALU_W-1:0] aluControl,
  output logic             illegal,
  output logic             retire
);

  state_e    state_q, state_d;
  alu_mode_e alu_mode;
  logic      pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, retire_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  always_comb begin
    adrSrc        = 1'b0;
    aluSrcA       = SRCA_PC;
    aluSrcB       = SRCB_RS2;
    resultSrc     = RES_ALUOUT;
    alu_mode      = ALU_MODE_ADD;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    retire_raw    = 1'b0;
    case (state_q)
      S_FETCH: begin
        aluSrcB      = SRCB_FOUR;
        resultSrc    = RES_ALU;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      // Precompute the branch target into ALUOut while the opcode is decoded.
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc     = RES_RDATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = mem_ready;
      end
      S_EXEC_R: begin
        aluSrcA  = SRCA_RS1;
        alu_mode = ALU_MODE_FUNCT;
      end
      S_EXEC_I: begin
        aluSrcA  = SRCA_RS1;
        aluSrcB  = SRCB_IMM;
        alu_mode = ALU_MODE_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA    = SRCA_RS1;
        alu_mode   = ALU_MODE_SUB;
        retire_raw = 1'b1;
        if (f3 == BR_F3_BEQ) begin
          pc_write_raw = zero;
        end else if (f3 == BR_F3_BNE && BR_EXT != 0) begin
          pc_write_raw = ~zero;
        end
      end
      // Jumps load the target into PC first, then form the link value PC+4.
      S_JAL: begin
        aluSrcA      = SRCA_OLDPC;
        aluSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      S_JALR1: begin
        aluSrcA      = SRCA_RS1;
        aluSrcB      = SRCB_IMM;
        resultSrc    = RES_ALU;
        pc_write_raw = 1'b1;
      end
      S_JALR2: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
      end
      default: ;
    endcase
  end

  alu_decoder_ext #(
    .ALU_W(ALU_W)
  ) u_alu_dec (
    .alu_mode_i   (alu_mode),
    .f3_i         (f3),
    .f7_i         (f7),
    .op5_i        (op[5]),
    .alu_control_o(aluControl)
  );

  assign immSrc  = imm_src_for(op);
  assign illegal = (state_q == S_ERROR);

  // Reset must silence strobes combinationally, even mid-cycle.
  assign pcWrite  = pc_write_raw  & ~rst;
  assign irWrite  = ir_write_raw  & ~rst;
  assign regWrite = reg_write_raw & ~rst;
  assign memWrite = mem_write_raw & ~rst;
  assign retire   = retire_raw    & ~rst;

endmodule

// File: tb/tb_mc_control_unit.sv
// Table-driven bench for mc_control_unit: two instances (ALU_W=4/BR_EXT=1 and
// ALU_W=3/BR_EXT=0) share stimulus; per-cycle expectations go through a queue.
module tb_mc_control_unit;

  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OPL   = 7'b0000011;
  localparam logic [6:0] OPS   = 7'b0100011;
  localparam logic [6:0] OPB   = 7'b1100011;
  localparam logic [6:0] OPJ   = 7'b1101111;
  localparam logic [6:0] OPJR  = 7'b1100111;
  localparam logic [6:0] OPLUI = 7'b0110111;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [3:0] alu4;
    logic [2:0] alu3;
    logic       pcw3;
    logic       ill;
    logic       ret;
  } exp_t;

  typedef struct {
    string      name;
    logic       r;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       mr;
    exp_t       x;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, mem_ready;

  logic       a_pcWrite, a_irWrite, a_regWrite, a_memWrite, a_adrSrc, a_illegal, a_retire;
  logic [1:0] a_aluSrcA, a_aluSrcB, a_resultSrc, a_immSrc;
  logic [3:0] a_aluControl;
  logic       b_pcWrite, b_irWrite, b_regWrite, b_memWrite, b_adrSrc, b_illegal, b_retire;
  logic [1:0] b_aluSrcA, b_aluSrcB, b_resultSrc, b_immSrc;
  logic [2:0] b_aluControl;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.ALU_W(4), .BR_EXT(1)) dut_a (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero), .mem_ready(mem_ready),
    .pcWrite(a_pcWrite), .irWrite(a_irWrite), .regWrite(a_regWrite), .memWrite(a_memWrite),
    .adrSrc(a_adrSrc), .aluSrcA(a_aluSrcA), .aluSrcB(a_aluSrcB), .resultSrc(a_resultSrc),
    .immSrc(a_immSrc), .aluControl(a_aluControl), .illegal(a_illegal), .retire(a_retire)
  );

  mc_control_unit #(.ALU_W(3), .BR_EXT(0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero), .mem_ready(mem_ready),
    .pcWrite(b_pcWrite), .irWrite(b_irWrite), .regWrite(b_regWrite), .memWrite(b_memWrite),
    .adrSrc(b_adrSrc), .aluSrcA(b_aluSrcA), .aluSrcB(b_aluSrcB), .resultSrc(b_resultSrc),
    .immSrc(b_immSrc), .aluControl(b_aluControl), .illegal(b_illegal), .retire(b_retire)
  );

  function automatic exp_t ex(input logic pcw, input logic irw, input logic rw, input logic mw,
                              input logic adr, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] res, input logic [1:0] imm, input logic [3:0] alu4,
                              input logic [2:0] alu3, input logic pcw3, input logic ill,
                              input logic ret);
    return {pcw, irw, rw, mw, adr, sa, sb, res, imm, alu4, alu3, pcw3, ill, ret};
  endfunction

  function automatic exp_t fetch_x(input logic [1:0] imm, input logic mr);
    return ex(mr, mr, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, imm, 4'h0, 3'h0, mr, 1'b0, 1'b0);
  endfunction

  function automatic exp_t decode_x(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, imm, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t wb_x(input logic [1:0] imm);
    return ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 4'h0, 3'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t mkv(input string nm, input logic r, input logic [6:0] o,
                               input logic [2:0] fn3, input logic fn7, input logic z,
                               input logic mr, input exp_t x);
    vec_t v;
    v.name = nm; v.r = r; v.op = o; v.f3 = fn3; v.f7 = fn7; v.zero = z; v.mr = mr; v.x = x;
    return v;
  endfunction

  task automatic add_vec(input string nm, input logic r, input logic [6:0] o, input logic [2:0] fn3,
                         input logic fn7, input logic z, input logic mr, input exp_t x);
    vecs.push_back(mkv(nm, r, o, fn3, fn7, z, mr, x));
  endtask

  task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] fn3,
                           input logic fn7, input logic [3:0] alu4, input logic [2:0] alu3);
    logic [1:0] sb;
    sb = (o == OPR) ? 2'b00 : 2'b01;
    add_vec({nm, "/fetch"},  1'b0, o, fn3, fn7, 1'b0, 1'b1, fetch_x(2'b00, 1'b1));
    add_vec({nm, "/decode"}, 1'b0, o, fn3, fn7, 1'b0, 1'b1, decode_x(2'b00));
    add_vec({nm, "/exec"},   1'b0, o, fn3, fn7, 1'b0, 1'b1,
            ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, sb, 2'b00, 2'b00, alu4, alu3, 1'b0, 1'b0, 1'b0));
    add_vec({nm, "/wb"},     1'b0, o, fn3, fn7, 1'b0, 1'b1, wb_x(2'b00));
  endtask

  task automatic br_instr(input string nm, input logic [2:0] fn3, input logic z,
                          input logic pcw, input logic pcw3);
    add_vec({nm, "/fetch"},  1'b0, OPB, fn3, 1'b0, z, 1'b1, fetch_x(2'b10, 1'b1));
    add_vec({nm, "/decode"}, 1'b0, OPB, fn3, 1'b0, z, 1'b0, decode_x(2'b10));
    add_vec({nm, "/branch"}, 1'b0, OPB, fn3, 1'b0, z, 1'b0,
            ex(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 4'b0001, 3'b001, pcw3, 1'b0, 1'b1));
  endtask

  task automatic check_cycle();
    exp_t        x;
    string       nm;
    logic [18:0] act_a, exp_a;
    logic [17:0] act_b, exp_b;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required a pending expectation");
      return;
    end
    x  = exp_q.pop_front();
    nm = name_q.pop_front();
    act_a = {a_pcWrite, a_irWrite, a_regWrite, a_memWrite, a_adrSrc, a_aluSrcA, a_aluSrcB,
             a_resultSrc, a_immSrc, a_aluControl, a_illegal, a_retire};
    exp_a = {x.pcw, x.irw, x.rw, x.mw, x.adr, x.sa, x.sb, x.res, x.imm, x.alu4, x.ill, x.ret};
    act_b = {b_pcWrite, b_irWrite, b_regWrite, b_memWrite, b_adrSrc, b_aluSrcA, b_aluSrcB,
             b_resultSrc, b_immSrc, b_aluControl, b_illegal, b_retire};
    exp_b = {x.pcw3, x.irw, x.rw, x.mw, x.adr, x.sa, x.sb, x.res, x.imm, x.alu3, x.ill, x.ret};
    n_tests++;
    if (act_a !== exp_a) begin
      n_fail++;
      $display("FAIL %s cfgA: got %h required %h", nm, act_a, exp_a);
    end
    n_tests++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL %s cfgB: got %h required %h", nm, act_b, exp_b);
    end
    $display("[TB] %-18s a=%h b=%h", nm, act_a, act_b);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst       = v.r;
    op        = v.op;
    f3        = v.f3;
    f7        = v.f7;
    zero      = v.zero;
    mem_ready = v.mr;
    exp_q.push_back(v.x);
    name_q.push_back(v.name);
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    exp_t mem_x, rdy_x, err_x;
    logic [9:0] strobes;
    rst = 1'b1; op = OPR; f3 = 3'b000; f7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

    add_vec("reset", 1'b1, OPR, 3'b000, 1'b0, 1'b0, 1'b1, fetch_x(2'b00, 1'b0));
    alu_instr("add",   OPR, 3'b000, 1'b0, 4'b0000, 3'b000);
    alu_instr("sub",   OPR, 3'b000, 1'b1, 4'b0001, 3'b001);
    alu_instr("addi7", OPI, 3'b000, 1'b1, 4'b0000, 3'b000);
    alu_instr("and",   OPR, 3'b111, 1'b0, 4'b0010, 3'b010);
    alu_instr("ori",   OPI, 3'b110, 1'b0, 4'b0011, 3'b011);
    alu_instr("slt",   OPR, 3'b010, 1'b0, 4'b0101, 3'b101);
    alu_instr("sra",   OPR, 3'b101, 1'b1, 4'b1000, 3'b000);
    alu_instr("srli",  OPI, 3'b101, 1'b0, 4'b0111, 3'b000);
    alu_instr("xor",   OPR, 3'b100, 1'b0, 4'b0100, 3'b000);
    alu_instr("sll",   OPR, 3'b001, 1'b0, 4'b0110, 3'b000);
    alu_instr("sltiu", OPI, 3'b011, 1'b0, 4'b1001, 3'b000);

    // lw with two fetch stalls and three memory-wait cycles
    mem_x = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add_vec("lw/fetch_wait", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b0, fetch_x(2'b00, 1'b0));
    add_vec("lw/fetch",  1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b1, fetch_x(2'b00, 1'b1));
    add_vec("lw/decode", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b1, decode_x(2'b00));
    add_vec("lw/memadr", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b1,
            ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) add_vec("lw/memread_wait", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b0, mem_x);
    add_vec("lw/memread_rdy", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b1, mem_x);
    add_vec("lw/memwb", 1'b0, OPL, 3'b010, 1'b0, 1'b0, 1'b0,
            ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0, 3'h0, 1'b0, 1'b0, 1'b1));

    // sw with one memory-wait cycle
    mem_x = ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    rdy_x = mem_x;
    rdy_x.ret = 1'b1;
    add_vec("sw/fetch",  1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b1, fetch_x(2'b01, 1'b1));
    add_vec("sw/decode", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, decode_x(2'b01));
    add_vec("sw/memadr", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0,
            ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    add_vec("sw/memwrite_wait", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, mem_x);
    add_vec("sw/memwrite_rdy",  1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b1, rdy_x);

    br_instr("bne_nz", 3'b001, 1'b0, 1'b1, 1'b0);
    br_instr("bne_z",  3'b001, 1'b1, 1'b0, 1'b0);
    br_instr("beq_z",  3'b000, 1'b1, 1'b1, 1'b1);
    br_instr("beq_nz", 3'b000, 1'b0, 1'b0, 1'b0);
    br_instr("blt_z",  3'b100, 1'b1, 1'b0, 1'b0);

    add_vec("jal/fetch",  1'b0, OPJ, 3'b000, 1'b0, 1'b0, 1'b1, fetch_x(2'b11, 1'b1));
    add_vec("jal/decode", 1'b0, OPJ, 3'b000, 1'b0, 1'b0, 1'b1, decode_x(2'b11));
    add_vec("jal/jal",    1'b0, OPJ, 3'b000, 1'b0, 1'b0, 1'b1,
            ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11, 4'h0, 3'h0, 1'b1, 1'b0, 1'b0));
    add_vec("jal/wb",     1'b0, OPJ, 3'b000, 1'b0, 1'b0, 1'b1, wb_x(2'b11));

    add_vec("jalr/fetch",  1'b0, OPJR, 3'b000, 1'b0, 1'b0, 1'b1, fetch_x(2'b00, 1'b1));
    add_vec("jalr/decode", 1'b0, OPJR, 3'b000, 1'b0, 1'b0, 1'b1, decode_x(2'b00));
    add_vec("jalr/jalr1",  1'b0, OPJR, 3'b000, 1'b0, 1'b0, 1'b1,
            ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 4'h0, 3'h0, 1'b1, 1'b0, 1'b0));
    add_vec("jalr/jalr2",  1'b0, OPJR, 3'b000, 1'b0, 1'b0, 1'b1,
            ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    add_vec("jalr/wb",     1'b0, OPJR, 3'b000, 1'b0, 1'b0, 1'b1, wb_x(2'b00));

    // Unsupported opcode: sticky ERROR for 10 cycles, then a reset pulse
    err_x = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 3'h0, 1'b0, 1'b1, 1'b0);
    add_vec("lui/fetch",  1'b0, OPLUI, 3'b000, 1'b0, 1'b0, 1'b1, fetch_x(2'b00, 1'b1));
    add_vec("lui/decode", 1'b0, OPLUI, 3'b000, 1'b0, 1'b0, 1'b1, decode_x(2'b00));
    for (int i = 0; i < 10; i++) add_vec("lui/error", 1'b0, OPLUI, 3'b000, 1'b0, 1'b0, 1'b1, err_x);
    add_vec("lui/reset",      1'b1, OPLUI, 3'b000, 1'b0, 1'b0, 1'b1, fetch_x(2'b00, 1'b0));
    add_vec("lui/after_rst",  1'b0, OPLUI, 3'b000, 1'b0, 1'b0, 1'b0, fetch_x(2'b00, 1'b0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset raised mid-cycle while a store waits on memory
    apply(mkv("swrst/fetch",  1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b1, fetch_x(2'b01, 1'b1)));
    apply(mkv("swrst/decode", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, decode_x(2'b01)));
    apply(mkv("swrst/memadr", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0,
              ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0)));
    apply(mkv("swrst/memwrite_wait", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, mem_x));
    #2;
    rst = 1'b1;
    #1;
    strobes = {a_memWrite, a_adrSrc, a_retire, a_pcWrite, a_irWrite,
               b_memWrite, b_adrSrc, b_retire, b_pcWrite, b_irWrite};
    n_tests++;
    if (strobes !== 10'b0) begin
      n_fail++;
      $display("FAIL swrst/async: got strobes %b required %b", strobes, 10'b0);
    end
    $display("[TB] %-18s strobes=%b", "swrst/async", strobes);
    apply(mkv("swrst/release", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, fetch_x(2'b01, 1'b0)));
    apply(mkv("swrst/fetch2",  1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b1, fetch_x(2'b01, 1'b1)));
    apply(mkv("swrst/decode2", 1'b0, OPS, 3'b010, 1'b0, 1'b0, 1'b0, decode_x(2'b01)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
